// File: rtl/twi_seq_pkg.sv
// Shared types and constants for the TWI transaction sequencer: FSM states,
// transaction step codes, TWI master register map and response error codes.
package twi_seq_pkg;

    typedef enum logic [3:0] {
        ST_INIT_BAUD, ST_INIT_EN, ST_IDLE, ST_SEND, ST_WAITW, ST_RESTART, ST_WAITC,
        ST_RECV, ST_WAITR, ST_RDDAT, ST_STOP, ST_DONE, ST_TO_DIS, ST_TO_EN
    } state_e;

    typedef enum logic [2:0] {
        STEP_ADDRW, STEP_REG, STEP_WDAT, STEP_RESTART, STEP_ADDRR, STEP_STOP
    } step_e;

    // TWI master window offsets and bit positions (io_s_h.v TWI_MASTER_* layout)
    localparam int TWI_MASTER_CTRLA  = 0;
    localparam int TWI_MASTER_CTRLC  = 2;
    localparam int TWI_MASTER_STATUS = 3;
    localparam int TWI_MASTER_BAUD   = 4;
    localparam int TWI_MASTER_DATA   = 6;

    localparam int TWI_MASTER_RIF_BP   = 7;
    localparam int TWI_MASTER_WIF_BP   = 6;
    localparam int TWI_MASTER_RXACK_BP = 4;

    localparam logic [7:0] TWI_MASTER_ENABLE_BM = 8'h08;
    localparam logic [7:0] TWI_MASTER_ACKACT_BM = 8'h04;
    localparam logic [1:0] TWI_CMD_NOACT     = 2'b00;
    localparam logic [1:0] TWI_CMD_REPSTART  = 2'b01;
    localparam logic [1:0] TWI_CMD_RECVTRANS = 2'b10;
    localparam logic [1:0] TWI_CMD_STOP      = 2'b11;

    localparam logic [1:0] RSP_ERR_OK      = 2'b00;
    localparam logic [1:0] RSP_ERR_ADDR    = 2'b01;
    localparam logic [1:0] RSP_ERR_DATA    = 2'b10;
    localparam logic [1:0] RSP_ERR_TIMEOUT = 2'b11;

    function automatic logic is_wait(input state_e s);
        return (s == ST_WAITW) || (s == ST_WAITC) || (s == ST_WAITR);
    endfunction

endpackage

// File: rtl/twi_seq_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the requester preferred next
// and flips to the other one after every grant.
module twi_seq_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    // grant selection and pointer update
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req[ptr_q]) begin
                gnt = ptr_q ? 2'b10 : 2'b01;
            end else if (req[~ptr_q]) begin
                gnt = ptr_q ? 2'b01 : 2'b10;
            end else begin
                gnt = 2'b00;
            end
            if (gnt[0]) begin
                ptr_d = 1'b1;
            end else if (gnt[1]) begin
                ptr_d = 1'b0;
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/twi_seq.sv
// TWI transaction sequencer: sole master of the TWI window, arbitrates two
// requesters and runs complete register write/read transactions.
// Optional: define TWI_SEQ_TIMEOUT_EN to bound every wait state by TIMEOUT_CYC.
module twi_seq
    import twi_seq_pkg::*;
#(
    parameter int          TWI_ADDRESS       = 0,
    parameter int          BUS_ADDR_DATA_LEN = 16,
    parameter logic [7:0]  BAUD_INIT         = 8'd24,
    parameter logic [19:0] TIMEOUT_CYC       = 20'hFFFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [1:0]                   req_rw,
    input  logic [13:0]                  req_dev,
    input  logic [15:0]                  req_reg,
    input  logic [15:0]                  req_wdata,
    output logic                         rsp_valid,
    output logic                         rsp_id,
    output logic [7:0]                   rsp_rdata,
    output logic [1:0]                   rsp_err,
    output logic                         busy,
    output logic [BUS_ADDR_DATA_LEN-1:0] m_addr,
    output logic                         m_wr,
    output logic                         m_rd,
    output logic [7:0]                   m_dout,
    input  logic [7:0]                   m_din
);

    localparam int AW = BUS_ADDR_DATA_LEN;
    localparam logic [AW-1:0] A_CTRLA  = AW'(TWI_ADDRESS + TWI_MASTER_CTRLA);
    localparam logic [AW-1:0] A_CTRLC  = AW'(TWI_ADDRESS + TWI_MASTER_CTRLC);
    localparam logic [AW-1:0] A_STATUS = AW'(TWI_ADDRESS + TWI_MASTER_STATUS);
    localparam logic [AW-1:0] A_BAUD   = AW'(TWI_ADDRESS + TWI_MASTER_BAUD);
    localparam logic [AW-1:0] A_DATA   = AW'(TWI_ADDRESS + TWI_MASTER_DATA);

    state_e          state_q, state_d;
    step_e           step_q, step_d;
    logic            id_q, id_d, rw_q, rw_d;
    logic [6:0]      dev_q, dev_d;
    logic [7:0]      reg_q, reg_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]      err_q, err_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic            m_wr_q, m_wr_d, m_rd_q, m_rd_d;
    logic [7:0]      m_dout_q, m_dout_d;
    logic [1:0]      req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;
    logic [1:0]      gnt_s;
    logic [7:0]      tx_byte_s;
`ifdef TWI_SEQ_TIMEOUT_EN
    logic [19:0]     tmo_q, tmo_d;
`endif

    twi_seq_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .en  (state_q == ST_IDLE),
        .gnt (gnt_s)
    );

    // byte placed on the bus by the SEND state for the current step
    always_comb begin
        case (step_q)
            STEP_ADDRW: tx_byte_s = {dev_q, 1'b0};
            STEP_REG:   tx_byte_s = reg_q;
            STEP_WDAT:  tx_byte_s = wdata_q;
            STEP_ADDRR: tx_byte_s = {dev_q, 1'b1};
            default:    tx_byte_s = 8'h00;
        endcase
    end

    // sequencer next state and registered bus/response outputs;
    // a poll result is valid in m_din only while the previous cycle's m_rd_q is high
    always_comb begin
        state_d = state_q;  step_d = step_q;  id_d = id_q;  rw_d = rw_q;
        dev_d = dev_q;  reg_d = reg_q;  wdata_d = wdata_q;  rdata_d = rdata_q;  err_d = err_q;
        m_addr_d = '0;  m_wr_d = 1'b0;  m_rd_d = 1'b0;  m_dout_d = 8'h00;
        req_ready_d = 2'b00;  rsp_valid_d = 1'b0;
        rsp_id_d = rsp_id_q;  rsp_rdata_d = rsp_rdata_q;  rsp_err_d = rsp_err_q;
        case (state_q)
            ST_INIT_BAUD: begin
                m_wr_d = 1'b1;  m_addr_d = A_BAUD;  m_dout_d = BAUD_INIT;  state_d = ST_INIT_EN;
            end
            ST_INIT_EN: begin
                m_wr_d = 1'b1;  m_addr_d = A_CTRLA;  m_dout_d = TWI_MASTER_ENABLE_BM;  state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (gnt_s != 2'b00) begin
                    req_ready_d = gnt_s;
                    id_d    = gnt_s[1];
                    rw_d    = gnt_s[1] ? req_rw[1] : req_rw[0];
                    dev_d   = gnt_s[1] ? req_dev[13:7] : req_dev[6:0];
                    reg_d   = gnt_s[1] ? req_reg[15:8] : req_reg[7:0];
                    wdata_d = gnt_s[1] ? req_wdata[15:8] : req_wdata[7:0];
                    rdata_d = 8'h00;
                    err_d   = RSP_ERR_OK;
                    step_d  = STEP_ADDRW;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                m_wr_d = 1'b1;  m_addr_d = A_DATA;  m_dout_d = tx_byte_s;  state_d = ST_WAITW;
            end
            ST_WAITW: begin
                if (m_rd_q && m_din[TWI_MASTER_WIF_BP]) begin
                    if (m_din[TWI_MASTER_RXACK_BP]) begin
                        err_d = ((step_q == STEP_ADDRW) || (step_q == STEP_ADDRR)) ? RSP_ERR_ADDR : RSP_ERR_DATA;
                        state_d = ST_STOP;
                    end else begin
                        case (step_q)
                            STEP_ADDRW: begin step_d = STEP_REG;  state_d = ST_SEND; end
                            STEP_REG: begin
                                if (rw_q) begin
                                    state_d = ST_RESTART;
                                end else begin
                                    step_d = STEP_WDAT;  state_d = ST_SEND;
                                end
                            end
                            STEP_ADDRR: state_d = ST_RECV;
                            default:    state_d = ST_STOP;
                        endcase
                    end
                end else begin
                    m_rd_d = 1'b1;  m_addr_d = A_STATUS;
                end
            end
            ST_RESTART: begin
                m_wr_d = 1'b1;  m_addr_d = A_CTRLC;  m_dout_d = {6'b000000, TWI_CMD_REPSTART};
                step_d = STEP_RESTART;  state_d = ST_WAITC;
            end
            ST_WAITC: begin
                if (m_rd_q && (m_din[1:0] == TWI_CMD_NOACT)) begin
                    if (step_q == STEP_RESTART) begin
                        step_d = STEP_ADDRR;  state_d = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    m_rd_d = 1'b1;  m_addr_d = A_CTRLC;
                end
            end
            ST_RECV: begin
                m_wr_d = 1'b1;  m_addr_d = A_CTRLC;
                m_dout_d = TWI_MASTER_ACKACT_BM | {6'b000000, TWI_CMD_RECVTRANS};
                state_d = ST_WAITR;
            end
            ST_WAITR: begin
                if (m_rd_q && m_din[TWI_MASTER_RIF_BP]) begin
                    state_d = ST_RDDAT;
                end else begin
                    m_rd_d = 1'b1;  m_addr_d = A_STATUS;
                end
            end
            ST_RDDAT: begin
                if (m_rd_q) begin
                    rdata_d = m_din;  state_d = ST_STOP;
                end else begin
                    m_rd_d = 1'b1;  m_addr_d = A_DATA;
                end
            end
            ST_STOP: begin
                m_wr_d = 1'b1;  m_addr_d = A_CTRLC;  m_dout_d = {6'b000000, TWI_CMD_STOP};
                step_d = STEP_STOP;  state_d = ST_WAITC;
            end
            ST_DONE: begin
                rsp_valid_d = 1'b1;  rsp_id_d = id_q;  rsp_rdata_d = rdata_q;  rsp_err_d = err_q;
                state_d = ST_IDLE;
            end
            ST_TO_DIS: begin
                m_wr_d = 1'b1;  m_addr_d = A_CTRLA;  m_dout_d = 8'h00;  state_d = ST_TO_EN;
            end
            ST_TO_EN: begin
                m_wr_d = 1'b1;  m_addr_d = A_CTRLA;  m_dout_d = TWI_MASTER_ENABLE_BM;  state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef TWI_SEQ_TIMEOUT_EN
        tmo_d = is_wait(state_q) ? (tmo_q + 20'd1) : 20'd0;
        if (is_wait(state_q) && (tmo_q == TIMEOUT_CYC)) begin
            m_rd_d = 1'b0;  m_addr_d = '0;  err_d = RSP_ERR_TIMEOUT;  state_d = ST_TO_DIS;
        end else begin
            err_d = err_d;
        end
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // state, transaction context and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT_BAUD;  step_q <= STEP_ADDRW;  id_q <= 1'b0;  rw_q <= 1'b0;
            dev_q <= 7'h00;  reg_q <= 8'h00;  wdata_q <= 8'h00;  rdata_q <= 8'h00;  err_q <= 2'b00;
            m_addr_q <= '0;  m_wr_q <= 1'b0;  m_rd_q <= 1'b0;  m_dout_q <= 8'h00;
            req_ready_q <= 2'b00;  rsp_valid_q <= 1'b0;  rsp_id_q <= 1'b0;
            rsp_rdata_q <= 8'h00;  rsp_err_q <= 2'b00;  busy_q <= 1'b1;
`ifdef TWI_SEQ_TIMEOUT_EN
            tmo_q <= 20'd0;
`endif
        end else begin
            state_q <= state_d;  step_q <= step_d;  id_q <= id_d;  rw_q <= rw_d;
            dev_q <= dev_d;  reg_q <= reg_d;  wdata_q <= wdata_d;  rdata_q <= rdata_d;  err_q <= err_d;
            m_addr_q <= m_addr_d;  m_wr_q <= m_wr_d;  m_rd_q <= m_rd_d;  m_dout_q <= m_dout_d;
            req_ready_q <= req_ready_d;  rsp_valid_q <= rsp_valid_d;  rsp_id_q <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;  rsp_err_q <= rsp_err_d;  busy_q <= busy_d;
`ifdef TWI_SEQ_TIMEOUT_EN
            tmo_q <= tmo_d;
`endif
        end
    end

    assign m_addr    = m_addr_q;
    assign m_wr      = m_wr_q;
    assign m_rd      = m_rd_q;
    assign m_dout    = m_dout_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule
